// File: rtl/dcpu_memctl_pkg.sv
// Shared definitions for the dcpu memory controller.
// State encodings, default I/O window base and the timeout read pattern.
package dcpu_memctl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RAM_WAIT = 2'd1,
        IO_REQ   = 2'd2,
        ACK      = 2'd3
    } state_e;

    localparam logic [15:0] IO_BASE_DEF = 16'hFF00;
    localparam logic [15:0] TMO_PAT     = 16'hDEAD;

endpackage

// File: rtl/dcpu_memctl_if.sv
// Core-side bus and external I/O port of the dcpu memory controller.
// master = core, slave = controller, io = external I/O device.
interface dcpu_memctl_if;

    logic        i_cs;
    logic        i_we;
    logic [15:0] i_addr;
    logic [15:0] i_dat;
    logic [15:0] o_dat;
    logic        o_ack;
    logic        o_err;

    logic        o_io_cs;
    logic        o_io_we;
    logic [7:0]  o_io_addr;
    logic [15:0] o_io_dat;
    logic [15:0] i_io_dat;
    logic        i_io_ack;

    modport master (
        output i_cs, i_we, i_addr, i_dat,
        input  o_dat, o_ack, o_err
    );

    modport slave (
        input  i_cs, i_we, i_addr, i_dat,
        output o_dat, o_ack, o_err,
        output o_io_cs, o_io_we, o_io_addr, o_io_dat,
        input  i_io_dat, i_io_ack
    );

    modport io (
        input  o_io_cs, o_io_we, o_io_addr, o_io_dat,
        output i_io_dat, i_io_ack
    );

endinterface

// File: rtl/dcpu_ram.sv
// Single-port synchronous RAM, 16-bit words, registered read data.
// Read-before-write on a shared address; contents are never reset.
module dcpu_ram #(
    parameter int unsigned AW = 12
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [15:0]   wdat,
    output logic [15:0]   rdat
);

    logic [15:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdat;
        end
        rdat <= mem[addr];
    end

endmodule

// File: rtl/dcpu_memctl.sv
// Bus slave behind the dcpu core: on-chip RAM with wait states plus
// a high-address I/O window with ack handshake and timeout.
module dcpu_memctl
    import dcpu_memctl_pkg::*;
#(
    parameter int unsigned AW      = 12,
    parameter int unsigned WAIT    = 1,
    parameter logic [15:0] IO_BASE = IO_BASE_DEF,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    dcpu_memctl_if.slave  bus
);

    localparam int unsigned   TW       = $clog2(TIMEOUT);
    localparam logic [3:0]    WAIT_LD  = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    state_e        state_q;
    logic [3:0]    cnt_q;
    logic [TW-1:0] tmo_q;
    logic          ack_q;
    logic          err_q;
    logic [15:0]   dat_q;
    logic          sel_q;
    logic          io_cs_q;
    logic          io_we_q;
    logic [7:0]    io_addr_q;
    logic [15:0]   io_dat_q;

    logic          is_io;
    logic          ram_we;
    logic [15:0]   ram_rdat;

    assign is_io = bus.i_addr >= IO_BASE;

    // Writes commit only on the edge that enters ACK, so aborts never write.
    assign ram_we = bus.i_cs && bus.i_we && !is_io &&
                    ((state_q == IDLE && WAIT == 0) ||
                     (state_q == RAM_WAIT && cnt_q == 4'd0));

    dcpu_ram #(
        .AW (AW)
    ) u_ram (
        .clk  (i_clk),
        .we   (ram_we),
        .addr (bus.i_addr[AW-1:0]),
        .wdat (bus.i_dat),
        .rdat (ram_rdat)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            tmo_q     <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            dat_q     <= '0;
            sel_q     <= 1'b0;
            io_cs_q   <= 1'b0;
            io_we_q   <= 1'b0;
            io_addr_q <= '0;
            io_dat_q  <= '0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.i_cs) begin
                        if (is_io) begin
                            io_cs_q   <= 1'b1;
                            io_we_q   <= bus.i_we;
                            io_addr_q <= bus.i_addr[7:0];
                            io_dat_q  <= bus.i_dat;
                            tmo_q     <= '0;
                            state_q   <= IO_REQ;
                        end else if (WAIT == 0) begin
                            ack_q   <= 1'b1;
                            sel_q   <= ~bus.i_we;
                            state_q <= ACK;
                        end else begin
                            cnt_q   <= WAIT_LD;
                            state_q <= RAM_WAIT;
                        end
                    end
                end
                RAM_WAIT: begin
                    if (!bus.i_cs) begin
                        state_q <= IDLE;
                    end else if (cnt_q == 4'd0) begin
                        ack_q   <= 1'b1;
                        sel_q   <= ~bus.i_we;
                        state_q <= ACK;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                IO_REQ: begin
                    if (!bus.i_cs) begin
                        io_cs_q <= 1'b0;
                        state_q <= IDLE;
                    end else if (bus.i_io_ack) begin
                        if (!bus.i_we) begin
                            dat_q <= bus.i_io_dat;
                        end
                        io_cs_q <= 1'b0;
                        ack_q   <= 1'b1;
                        state_q <= ACK;
                    end else if (tmo_q == TMO_LAST) begin
                        if (!bus.i_we) begin
                            dat_q <= TMO_PAT;
                        end
                        io_cs_q <= 1'b0;
                        ack_q   <= 1'b1;
                        err_q   <= 1'b1;
                        state_q <= ACK;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                ACK: begin
                    // Freeze the RAM word so o_dat holds while the RAM keeps reading.
                    if (sel_q) begin
                        dat_q <= ram_rdat;
                    end
                    sel_q   <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.o_dat     = sel_q ? ram_rdat : dat_q;
    assign bus.o_ack     = ack_q;
    assign bus.o_err     = err_q;
    assign bus.o_io_cs   = io_cs_q;
    assign bus.o_io_we   = io_we_q;
    assign bus.o_io_addr = io_addr_q;
    assign bus.o_io_dat  = io_dat_q;

endmodule

// File: tb/tb_dcpu_memctl.sv
// Directed bench for dcpu_memctl: three instances cover WAIT=1/TIMEOUT=8,
// WAIT=0 and WAIT=3; inputs change and outputs are sampled on negedge.
module tb_dcpu_memctl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    dcpu_memctl_if bus_a ();
    dcpu_memctl_if bus_b ();
    dcpu_memctl_if bus_c ();

    dcpu_memctl #(.WAIT(1), .TIMEOUT(8)) u_a (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus_a)
    );

    dcpu_memctl #(.WAIT(0)) u_b (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus_b)
    );

    dcpu_memctl #(.WAIT(3)) u_c (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus_c)
    );

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: timeout expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_a.i_cs = 0; bus_a.i_we = 0; bus_a.i_addr = 0; bus_a.i_dat = 0;
        bus_a.i_io_dat = 0; bus_a.i_io_ack = 0;
        bus_b.i_cs = 0; bus_b.i_we = 0; bus_b.i_addr = 0; bus_b.i_dat = 0;
        bus_b.i_io_dat = 0; bus_b.i_io_ack = 0;
        bus_c.i_cs = 0; bus_c.i_we = 0; bus_c.i_addr = 0; bus_c.i_dat = 0;
        bus_c.i_io_dat = 0; bus_c.i_io_ack = 0;

        // reset state
        #2;
        chk("rst_ack", 16'(bus_a.o_ack), 16'h0);
        chk("rst_err", 16'(bus_a.o_err), 16'h0);
        chk("rst_dat", bus_a.o_dat, 16'h0);
        chk("rst_io_cs", 16'(bus_a.o_io_cs), 16'h0);
        chk("rst_io_we", 16'(bus_a.o_io_we), 16'h0);
        chk("rst_io_addr", 16'(bus_a.o_io_addr), 16'h0);
        chk("rst_io_dat", bus_a.o_io_dat, 16'h0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        // 1: WAIT=1 write then read
        bus_a.i_cs = 1; bus_a.i_we = 1;
        bus_a.i_addr = 16'h0010; bus_a.i_dat = 16'h1234;
        @(negedge clk);
        chk("t1_wr_ack_c1", 16'(bus_a.o_ack), 16'h0);
        @(negedge clk);
        chk("t1_wr_ack_c2", 16'(bus_a.o_ack), 16'h1);
        bus_a.i_cs = 0;
        @(negedge clk);
        chk("t1_ack_drop", 16'(bus_a.o_ack), 16'h0);
        bus_a.i_cs = 1; bus_a.i_we = 0;
        @(negedge clk);
        chk("t1_rd_ack_c1", 16'(bus_a.o_ack), 16'h0);
        @(negedge clk);
        chk("t1_rd_ack_c2", 16'(bus_a.o_ack), 16'h1);
        chk("t1_rd_dat", bus_a.o_dat, 16'h1234);
        bus_a.i_cs = 0;
        @(negedge clk);

        // 2: WAIT=0 back-to-back reads with aliasing
        bus_b.i_cs = 1; bus_b.i_we = 1;
        bus_b.i_addr = 16'h0000; bus_b.i_dat = 16'hA5A5;
        @(negedge clk);
        chk("t2_wr_ack", 16'(bus_b.o_ack), 16'h1);
        bus_b.i_cs = 0;
        @(negedge clk);
        bus_b.i_cs = 1; bus_b.i_we = 0; bus_b.i_addr = 16'h0000;
        @(negedge clk);
        chk("t2_rd0_ack", 16'(bus_b.o_ack), 16'h1);
        chk("t2_rd0_dat", bus_b.o_dat, 16'hA5A5);
        bus_b.i_addr = 16'h1000;
        @(negedge clk);
        chk("t2_gap_ack", 16'(bus_b.o_ack), 16'h0);
        chk("t2_gap_dat", bus_b.o_dat, 16'hA5A5);
        @(negedge clk);
        chk("t2_rd1_ack", 16'(bus_b.o_ack), 16'h1);
        chk("t2_rd1_dat", bus_b.o_dat, 16'hA5A5);
        bus_b.i_cs = 0;
        @(negedge clk);

        // 3: I/O read with ack three cycles after o_io_cs
        bus_a.i_cs = 1; bus_a.i_we = 0; bus_a.i_addr = 16'hFF05;
        @(negedge clk);
        chk("t3_io_cs", 16'(bus_a.o_io_cs), 16'h1);
        chk("t3_io_addr", 16'(bus_a.o_io_addr), 16'h0005);
        chk("t3_io_we", 16'(bus_a.o_io_we), 16'h0);
        chk("t3_ack_early", 16'(bus_a.o_ack), 16'h0);
        @(negedge clk);
        @(negedge clk);
        bus_a.i_io_ack = 1; bus_a.i_io_dat = 16'hBEEF;
        @(negedge clk);
        bus_a.i_io_ack = 0;
        chk("t3_ack", 16'(bus_a.o_ack), 16'h1);
        chk("t3_dat", bus_a.o_dat, 16'hBEEF);
        chk("t3_err", 16'(bus_a.o_err), 16'h0);
        chk("t3_io_cs_drop", 16'(bus_a.o_io_cs), 16'h0);
        bus_a.i_cs = 0;
        @(negedge clk);

        // 4: I/O timeout after 8 cycles in IO_REQ
        bus_a.i_cs = 1; bus_a.i_we = 0; bus_a.i_addr = 16'hFF00;
        repeat (8) @(negedge clk);
        chk("t4_ack_c8", 16'(bus_a.o_ack), 16'h0);
        chk("t4_io_cs_c8", 16'(bus_a.o_io_cs), 16'h1);
        @(negedge clk);
        chk("t4_ack", 16'(bus_a.o_ack), 16'h1);
        chk("t4_err", 16'(bus_a.o_err), 16'h1);
        chk("t4_dat", bus_a.o_dat, 16'hDEAD);
        chk("t4_io_cs", 16'(bus_a.o_io_cs), 16'h0);
        bus_a.i_cs = 0;
        @(negedge clk);
        chk("t4_err_pulse", 16'(bus_a.o_err), 16'h0);

        // 5: WAIT=3 aborted write leaves prior contents
        bus_c.i_cs = 1; bus_c.i_we = 1;
        bus_c.i_addr = 16'h0020; bus_c.i_dat = 16'h1111;
        repeat (3) @(negedge clk);
        chk("t5_pre_ack_c3", 16'(bus_c.o_ack), 16'h0);
        @(negedge clk);
        chk("t5_pre_ack_c4", 16'(bus_c.o_ack), 16'h1);
        bus_c.i_cs = 0;
        @(negedge clk);
        bus_c.i_cs = 1; bus_c.i_dat = 16'h5555;
        @(negedge clk);
        bus_c.i_cs = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t5_abort_ack", 16'(bus_c.o_ack), 16'h0);
        end
        bus_c.i_cs = 1; bus_c.i_we = 0;
        repeat (4) @(negedge clk);
        chk("t5_rd_ack", 16'(bus_c.o_ack), 16'h1);
        chk("t5_rd_dat", bus_c.o_dat, 16'h1111);
        bus_c.i_cs = 0;
        @(negedge clk);

        // 6: asynchronous reset mid IO_REQ
        bus_a.i_cs = 1; bus_a.i_we = 0; bus_a.i_addr = 16'hFF10;
        @(negedge clk);
        chk("t6_io_cs", 16'(bus_a.o_io_cs), 16'h1);
        #2 rst_n = 0;
        #1;
        chk("t6_rst_io_cs", 16'(bus_a.o_io_cs), 16'h0);
        chk("t6_rst_ack", 16'(bus_a.o_ack), 16'h0);
        chk("t6_rst_dat", bus_a.o_dat, 16'h0);
        bus_a.i_cs = 0;
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        bus_a.i_cs = 1; bus_a.i_we = 0; bus_a.i_addr = 16'h0010;
        @(negedge clk);
        chk("t6_rd_ack_c1", 16'(bus_a.o_ack), 16'h0);
        @(negedge clk);
        chk("t6_rd_ack_c2", 16'(bus_a.o_ack), 16'h1);
        chk("t6_rd_dat", bus_a.o_dat, 16'h1234);
        bus_a.i_cs = 0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
